uart_rx_fifo: RTL
=================

Name: uart_rx_fifo

Overview:
Memory-mapped UART receiver for the SOC's currently unused RXD pin. It deserialises 8N1 frames into bytes and buffers them in a small show-ahead FIFO. The IO readback mux reads the head byte and status combinationally, the same way it reads the GPIO block. A CPU load from the RX data word pops one byte.

Parameters:
CLK_FREQ_HZ, 12000000, system clock frequency.
BAUD_RATE, 9600, line rate. CLKS_PER_BIT = CLK_FREQ_HZ/BAUD_RATE (integer division); must be >= 4.
FIFO_DEPTH, 8, receive buffer entries; power of two, >= 2.

Ports:
clk  in  1  system clock
resetn  in  1  synchronous active-low reset
rxd  in  1  asynchronous serial input, idle high
rd_en  in  1  pop strobe; the SOC asserts it for exactly one cycle per CPU load of the data word
clr_err  in  1  clears the sticky error flags
rdata  out  8  head byte of the FIFO; 0 when empty
rx_valid  out  1  FIFO non-empty
fifo_full  out  1  FIFO holds FIFO_DEPTH bytes
overrun  out  1  sticky: a byte was dropped because the FIFO was full
frame_err  out  1  sticky: stop bit sampled low
parity_err  out  1  sticky: parity mismatch; tied 0 without the optional feature

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on resetn; it is sampled only on the rising edge of clk.
- Input synchroniser: rxd passes through a 2-flop synchroniser (rxd_s). Both flops reset to 1. All decisions below use rxd_s.
- Reset values: FIFO empty; rdata=0, rx_valid=0, fifo_full=0, overrun=0, frame_err=0, parity_err=0. FSM enters RECOVER and the bit counter clears. Reset mid-frame discards the partial byte.
- FSM states: RECOVER, IDLE, START, DATA, [PARITY], STOP.
  - RECOVER: wait until rxd_s has been high for CLKS_PER_BIT consecutive cycles, then go to IDLE. Any low sample restarts the count.
  - IDLE: rxd_s==0 -> START, with the baud counter cleared.
  - START: at count CLKS_PER_BIT/2 - 1, resample. If rxd_s==1 it was a glitch: go to IDLE, nothing recorded. If rxd_s==0 go to DATA with the counter cleared.
  - DATA: sample every CLKS_PER_BIT cycles (mid-bit). Shift LSB first into an 8-bit register. After bit 7 go to STOP (or PARITY when enabled).
  - STOP: sample one bit time later.
    - rxd_s==1: push the byte, go to IDLE.
    - rxd_s==0: set frame_err, discard the byte, go to RECOVER (covers break conditions).
- Push timing: the byte is written on the STOP sample cycle. rx_valid rises on the next cycle.
- FIFO: show-ahead. rdata is the head entry, registered storage with a combinational read.
  - Pop on rd_en when non-empty. rd_en on an empty FIFO is ignored and has no error effect.
  - Pointers are $clog2(FIFO_DEPTH) bits and wrap naturally. Occupancy counter is $clog2(FIFO_DEPTH)+1 bits.
- Simultaneous push and pop:
  - FIFO full: pop first, push accepted, occupancy unchanged, no overrun.
  - FIFO empty: pop ignored, push accepted.
- Push when full without a pop: byte dropped, overrun set, contents unchanged.
- Sticky flags: clr_err clears all sticky flags. If clr_err and a new error occur in the same cycle, set wins.
- Reception continues regardless of error flags.

Optional Feature:
UART_RX_PARITY_EN
- Defined: PARITY state between DATA and STOP samples an even-parity bit one bit time after bit 7. On mismatch, set parity_err; the stop bit is still checked, and the byte is discarded whatever the stop result. Frame is 9E1 on the wire (11 bit times).
- Undefined: no PARITY state; DATA goes directly to STOP; parity_err is a constant 0.

Decomposition:
- Shared package uart_pkg: FSM state encoding localparams; CLKS_PER_BIT derivation function; IO word-address bit constants for the RX data and RX status words, so the SOC mux and firmware headers agree.
- One natural sub-module, sync_fifo (parameters WIDTH, DEPTH). It has push/pop/full/empty/head ports and owns the pointer, occupancy and simultaneous-operation rules.
- The FSM and baud counter stay in uart_rx_fifo.

Test Plan:
All scenarios use CLK_FREQ_HZ=16, BAUD_RATE=1, so CLKS_PER_BIT=16.
1. Send 0xA5 (8N1) after RECOVER -> rx_valid=1 on the cycle after the STOP sample; rdata=0xA5. One rd_en pulse -> rx_valid=0, rdata=0.
2. Low pulse of 5 cycles on an idle line -> no START-to-DATA transition, rx_valid stays 0, no flags.
3. Send 0x3C with the stop bit held low for 20 cycles -> frame_err=1, FIFO empty. A following 0x11 is received only after 16 high cycles. clr_err -> frame_err=0.
4. Send 9 bytes 0x01..0x09 with no reads (FIFO_DEPTH=8) -> fifo_full=1, overrun=1. Eight pops return 0x01..0x08 in order.
5. With FIFO full, assert rd_en on the push cycle of a 9th byte 0x55 -> overrun stays 0, occupancy 8; the last pop returns 0x55.
6. Assert resetn=0 for one cycle mid-DATA of 0xF0 -> all outputs 0. The next full frame 0x0F is received correctly. With UART_RX_PARITY_EN, 0x0F sent with odd parity sets parity_err=1 and leaves the FIFO empty.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART RX definitions: FSM state encoding, bit-time derivation and the
// IO word-address / status-bit map used by the SOC readback mux and firmware.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_RECOVER = 3'd0,
        ST_IDLE    = 3'd1,
        ST_START   = 3'd2,
        ST_DATA    = 3'd3,
        ST_PARITY  = 3'd4,
        ST_STOP    = 3'd5
    } rx_state_e;

    localparam logic [3:0] RX_DATA_WORD_ADDR = 4'h0;
    localparam logic [3:0] RX_STAT_WORD_ADDR = 4'h1;

    localparam int RX_STAT_VALID_BIT   = 0;
    localparam int RX_STAT_FULL_BIT    = 1;
    localparam int RX_STAT_OVERRUN_BIT = 2;
    localparam int RX_STAT_FRAME_BIT   = 3;
    localparam int RX_STAT_PARITY_BIT  = 4;

    function automatic int clks_per_bit(input int clk_freq_hz, input int baud_rate);
        return clk_freq_hz / baud_rate;
    endfunction

    function automatic logic even_parity(input logic [7:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO: registered storage, combinational head read,
// full-FIFO push accepted when a pop lands on the same edge.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W:0]   count_r;
    logic             pop_ok_s;
    logic             push_ok_s;

    assign empty     = (count_r == {(PTR_W+1){1'b0}});
    assign full      = (count_r == (PTR_W+1)'(DEPTH));
    assign pop_ok_s  = pop & ~empty;
    assign push_ok_s = push & (~full | pop_ok_s);
    assign head      = empty ? {WIDTH{1'b0}} : mem_r[rd_ptr_r];

    // Storage write; contents need no reset since head is gated while empty.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    // Pointer and occupancy update.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {(PTR_W+1){1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + 1'b1;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + 1'b1;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// Memory-mapped UART receiver (8N1) feeding a show-ahead byte FIFO.
// Define UART_RX_PARITY_EN for 9E1 frames with even-parity checking.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 12000000,
    parameter int BAUD_RATE   = 9600,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       rxd,
    input  logic       rd_en,
    input  logic       clr_err,
    output logic [7:0] rdata,
    output logic       rx_valid,
    output logic       fifo_full,
    output logic       overrun,
    output logic       frame_err,
    output logic       parity_err
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ_HZ, BAUD_RATE);
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_END = CNT_W'(CLKS_PER_BIT / 2 - 1);

    logic             rxd_meta_r;
    logic             rxd_s;
    rx_state_e        state_r;
    rx_state_e        state_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_s;
    logic [2:0]       bit_cnt_r;
    logic [2:0]       bit_cnt_s;
    logic [7:0]       shift_r;
    logic [7:0]       shift_s;
    logic             bit_end_s;
    logic             push_s;
    logic             frame_set_s;
    logic             overrun_set_s;
    logic             fifo_full_s;
    logic             fifo_empty_s;
    logic             overrun_r;
    logic             frame_err_r;
`ifdef UART_RX_PARITY_EN
    logic             par_bad_r;
    logic             par_bad_s;
    logic             par_set_s;
    logic             parity_err_r;
`endif

    // Two-flop synchroniser for the asynchronous line, idle-high after reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            rxd_meta_r <= 1'b1;
            rxd_s      <= 1'b1;
        end else begin
            rxd_meta_r <= rxd;
            rxd_s      <= rxd_meta_r;
        end
    end

    assign bit_end_s = (cnt_r == BIT_END);

    // Receive FSM next-state, baud counter and shift logic.
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        bit_cnt_s   = bit_cnt_r;
        shift_s     = shift_r;
        push_s      = 1'b0;
        frame_set_s = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_s   = par_bad_r;
        par_set_s   = 1'b0;
`endif
        case (state_r)
            ST_RECOVER: begin
                if (!rxd_s) begin
                    cnt_s = CNT_ZERO;
                end else if (bit_end_s) begin
                    state_s = ST_IDLE;
                    cnt_s   = CNT_ZERO;
                end else begin
                    cnt_s = cnt_r + 1'b1;
                end
            end
            ST_IDLE: begin
                cnt_s = CNT_ZERO;
                if (!rxd_s) begin
                    state_s = ST_START;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (cnt_r == HALF_END) begin
                    cnt_s     = CNT_ZERO;
                    bit_cnt_s = 3'd0;
`ifdef UART_RX_PARITY_EN
                    par_bad_s = 1'b0;
`endif
                    if (rxd_s) begin
                        state_s = ST_IDLE;
                    end else begin
                        state_s = ST_DATA;
                    end
                end else begin
                    cnt_s = cnt_r + 1'b1;
                end
            end
            ST_DATA: begin
                if (bit_end_s) begin
                    cnt_s     = CNT_ZERO;
                    shift_s   = {rxd_s, shift_r[7:1]};
                    bit_cnt_s = bit_cnt_r + 3'd1;
                    if (bit_cnt_r == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_s = ST_PARITY;
`else
                        state_s = ST_STOP;
`endif
                    end else begin
                        state_s = ST_DATA;
                    end
                end else begin
                    cnt_s = cnt_r + 1'b1;
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (bit_end_s) begin
                    cnt_s     = CNT_ZERO;
                    par_bad_s = rxd_s ^ even_parity(shift_r);
                    par_set_s = rxd_s ^ even_parity(shift_r);
                    state_s   = ST_STOP;
                end else begin
                    cnt_s = cnt_r + 1'b1;
                end
            end
`endif
            ST_STOP: begin
                if (bit_end_s) begin
                    cnt_s = CNT_ZERO;
                    if (rxd_s) begin
`ifdef UART_RX_PARITY_EN
                        push_s = ~par_bad_r;
`else
                        push_s = 1'b1;
`endif
                        state_s = ST_IDLE;
                    end else begin
                        // Low stop bit (or break): wait for a clean idle line.
                        frame_set_s = 1'b1;
                        state_s     = ST_RECOVER;
                    end
                end else begin
                    cnt_s = cnt_r + 1'b1;
                end
            end
            default: begin
                state_s = ST_RECOVER;
                cnt_s   = CNT_ZERO;
            end
        endcase
    end

    // Receive FSM state registers.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r   <= ST_RECOVER;
            cnt_r     <= CNT_ZERO;
            bit_cnt_r <= 3'd0;
            shift_r   <= 8'h00;
`ifdef UART_RX_PARITY_EN
            par_bad_r <= 1'b0;
`endif
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            bit_cnt_r <= bit_cnt_s;
            shift_r   <= shift_s;
`ifdef UART_RX_PARITY_EN
            par_bad_r <= par_bad_s;
`endif
        end
    end

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (push_s),
        .wdata  (shift_r),
        .pop    (rd_en),
        .full   (fifo_full_s),
        .empty  (fifo_empty_s),
        .head   (rdata)
    );

    // A same-edge pop makes room, so only an unpaired push into a full FIFO drops.
    assign overrun_set_s = push_s & fifo_full_s & ~rd_en;

    // Sticky error flags; a new error beats a simultaneous clear.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            overrun_r   <= 1'b0;
            frame_err_r <= 1'b0;
        end else begin
            if (overrun_set_s) begin
                overrun_r <= 1'b1;
            end else if (clr_err) begin
                overrun_r <= 1'b0;
            end else begin
                overrun_r <= overrun_r;
            end
            if (frame_set_s) begin
                frame_err_r <= 1'b1;
            end else if (clr_err) begin
                frame_err_r <= 1'b0;
            end else begin
                frame_err_r <= frame_err_r;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    // Sticky parity flag, same set-over-clear priority.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            parity_err_r <= 1'b0;
        end else if (par_set_s) begin
            parity_err_r <= 1'b1;
        end else if (clr_err) begin
            parity_err_r <= 1'b0;
        end else begin
            parity_err_r <= parity_err_r;
        end
    end

    assign parity_err = parity_err_r;
`else
    assign parity_err = 1'b0;
`endif

    assign rx_valid  = ~fifo_empty_s;
    assign fifo_full = fifo_full_s;
    assign overrun   = overrun_r;
    assign frame_err = frame_err_r;

endmodule
